// File: rtl/chandrakanth_simple_pkg.sv
// Shared definitions for the Tiny Tapeout accumulator ALU: datapath width,
// opcode encoding and the bit positions of the status flags on uio_out.
package chandrakanth_simple_pkg;

  localparam int WIDTH = 8;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_LOAD = 3'd1,
    OP_ADD  = 3'd2,
    OP_SUB  = 3'd3,
    OP_AND  = 3'd4,
    OP_OR   = 3'd5,
    OP_XOR  = 3'd6,
    OP_SHL  = 3'd7
  } opcode_e;

  // Flag positions within uio_out; the low nibble is unused and driven 0.
  localparam int FLAG_Z = 7;
  localparam int FLAG_C = 6;
  localparam int FLAG_N = 5;
  localparam int FLAG_V = 4;

  localparam logic [WIDTH-1:0] UIO_OE_MASK = 8'hF0;

  // Z and N come straight from the accumulator; C and V are stored flags.
  function automatic logic [WIDTH-1:0] pack_status(input logic [WIDTH-1:0] acc,
                                                   input logic             c,
                                                   input logic             v);
    logic [WIDTH-1:0] status;
    status         = '0;
    status[FLAG_Z] = (acc == '0);
    status[FLAG_C] = c;
    status[FLAG_N] = acc[WIDTH-1];
    status[FLAG_V] = v;
    return status;
  endfunction

endpackage

// File: rtl/chandrakanth_simple_circuit_alu8.sv
// Combinational 8-bit ALU: computes the next accumulator value and the
// carry/borrow and signed-overflow flags for one opcode.
module alu8
  import chandrakanth_simple_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             c,
  output logic             v
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  // The extra top bit is the carry for ADD and the borrow for SUB.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  // NOTE: every output gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    result = a;
    c      = 1'b0;
    v      = 1'b0;
    case (opcode_e'(op))
      OP_NOP:  result = a;
      OP_LOAD: result = b;
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        c      = sum[WIDTH];
        v      = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        result = diff[WIDTH-1:0];
        c      = diff[WIDTH];
        v      = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SHL: begin
        result = {a[WIDTH-2:0], 1'b0};
        c      = a[WIDTH-1];
        v      = a[WIDTH-1] ^ a[WIDTH-2];
      end
      default: result = a;
    endcase
  end

endmodule

// File: rtl/chandrakanth_simple_circuit.sv
// Tiny Tapeout wrapper for the accumulator ALU: holds ACC, C and V, executes
// one opcode per strobed cycle and packs the flags onto the upper uio pins.
module chandrakanth_simple_circuit
  import chandrakanth_simple_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [WIDTH-1:0] acc;
  logic             c_q;
  logic             v_q;

  logic [WIDTH-1:0] alu_result;
  logic             alu_c;
  logic             alu_v;
  logic [2:0]       op;
  logic             execute;

  // Upper uio_in bits are read back from our own output drivers.
  logic             unused_uio_hi;
  assign unused_uio_hi = ^uio_in[7:4];

  assign op      = uio_in[2:0];
  assign execute = ena & uio_in[3];

  alu8 u_alu (
    .a      (acc),
    .b      (ui_in),
    .op     (op),
    .result (alu_result),
    .c      (alu_c),
    .v      (alu_v)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // The execute qualifier is only sampled on clock edges, so releasing
  // rst_n can never trigger an operation on its own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      c_q <= 1'b0;
      v_q <= 1'b0;
    end else if (execute && (opcode_e'(op) != OP_NOP)) begin
      acc <= alu_result;
      c_q <= alu_c;
      v_q <= alu_v;
    end
  end

  assign uo_out  = acc;
  assign uio_out = pack_status(acc, c_q, v_q);
  assign uio_oe  = UIO_OE_MASK;

endmodule

// File: tb/tb_chandrakanth_simple_circuit.sv
// Self-checking bench for the accumulator ALU: an arithmetic reference model
// compared every falling edge, plus directed vectors with literal results.
module tb_chandrakanth_simple_circuit;

  localparam logic [2:0] NOP  = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] ADD  = 3'd2;
  localparam logic [2:0] SUB  = 3'd3;
  localparam logic [2:0] AND_ = 3'd4;
  localparam logic [2:0] OR_  = 3'd5;
  localparam logic [2:0] XOR_ = 3'd6;
  localparam logic [2:0] SHL  = 3'd7;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b1;
  logic       ena    = 1'b0;
  logic [7:0] ui_in  = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  chandrakanth_simple_circuit dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on unsigned/signed values.
  int m_acc = 0;
  bit m_c   = 1'b0;
  bit m_v   = 1'b0;
  int ma, mb, ms, msv;

  function automatic int sgn(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_acc = 0;
      m_c   = 1'b0;
      m_v   = 1'b0;
    end else if (ena && uio_in[3]) begin
      ma = m_acc;
      mb = int'(ui_in);
      case (uio_in[2:0])
        LOAD: begin m_acc = mb; m_c = 0; m_v = 0; end
        ADD: begin
          ms    = ma + mb;
          m_acc = ms % 256;
          m_c   = (ms > 255);
          msv   = sgn(ma) + sgn(mb);
          m_v   = (msv > 127) || (msv < -128);
        end
        SUB: begin
          m_acc = (ma - mb + 256) % 256;
          m_c   = (ma < mb);
          msv   = sgn(ma) - sgn(mb);
          m_v   = (msv > 127) || (msv < -128);
        end
        AND_: begin m_acc = ma & mb; m_c = 0; m_v = 0; end
        OR_:  begin m_acc = ma | mb; m_c = 0; m_v = 0; end
        XOR_: begin m_acc = ma ^ mb; m_c = 0; m_v = 0; end
        SHL: begin
          m_acc = (ma * 2) % 256;
          m_c   = (ma >= 128);
          msv   = sgn(ma) * 2;
          m_v   = (msv > 127) || (msv < -128);
        end
        default: ;
      endcase
    end
  end

  function automatic logic [7:0] model_status();
    return {(m_acc == 0), m_c, (m_acc >= 128), m_v, 4'b0000};
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_acc", uo_out, m_acc[7:0]);
      check("model_flags", uio_out, model_status());
      check("uio_oe", uio_oe, 8'hF0);
    end
  end

  // One strobed operation with junk in the ignored uio_in nibble.
  task automatic exec(input string name, input logic [2:0] op, input logic [7:0] b,
                      input logic [7:0] e_acc, input logic [7:0] e_st);
    logic [3:0] junk;
    junk   = 4'($urandom_range(15));
    uio_in = {junk, 1'b1, op};
    ui_in  = b;
    @(posedge clk);
    #1;
    uio_in[3] = 1'b0;
    check({name, "_acc"}, uo_out, e_acc);
    check({name, "_flags"}, uio_out, e_st);
    check({name, "_pin_model"}, m_acc[7:0], e_acc);
  endtask

  initial begin
    #3 rst_n = 1'b0;
    #1;
    check("reset_acc", uo_out, 8'h00);
    check("reset_flags", uio_out, 8'h80);
    check("reset_oe", uio_oe, 8'hF0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    ena    = 1'b1;
    cmp_en = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("idle_acc", uo_out, 8'h00);
    check("idle_flags", uio_out, 8'h80);

    exec("load7f", LOAD, 8'h7F, 8'h7F, 8'h00);
    exec("add_ovf", ADD, 8'h01, 8'h80, 8'h30);
    exec("loadff", LOAD, 8'hFF, 8'hFF, 8'h20);
    exec("add_wrap", ADD, 8'h01, 8'h00, 8'hC0);
    exec("sub_borrow", SUB, 8'h01, 8'hFF, 8'h60);
    exec("loadf0", LOAD, 8'hF0, 8'hF0, 8'h20);
    exec("and", AND_, 8'h3C, 8'h30, 8'h00);
    exec("or", OR_, 8'h0F, 8'h3F, 8'h00);
    exec("xor", XOR_, 8'hFF, 8'hC0, 8'h20);
    exec("shl_c", SHL, 8'h00, 8'h80, 8'h60);
    exec("sub_ovf", SUB, 8'h01, 8'h7F, 8'h10);
    exec("shl_v", SHL, 8'h00, 8'hFE, 8'h30);
    exec("load00", LOAD, 8'h00, 8'h00, 8'h80);

    // Strobe held high re-executes ADD every cycle.
    uio_in = {4'h0, 1'b1, ADD};
    ui_in  = 8'h01;
    repeat (3) @(posedge clk);
    #1;
    check("held_acc", uo_out, 8'h03);
    check("held_flags", uio_out, 8'h00);

    // ena low overrides a strobed ADD.
    ena = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    uio_in[3] = 1'b0;
    ena       = 1'b1;
    check("ena_off_acc", uo_out, 8'h03);

    exec("nop", NOP, 8'hFF, 8'h03, 8'h00);
    exec("load55", LOAD, 8'h55, 8'h55, 8'h00);

    // Asynchronous reset between edges, then release with no strobe.
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_acc", uo_out, 8'h00);
    check("async_rst_flags", uio_out, 8'h80);
    uio_in = {4'h0, 1'b0, LOAD};
    ui_in  = 8'hAA;
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_acc", uo_out, 8'h00);
    check("post_rst_flags", uio_out, 8'h80);

    exec("first_after_rst", LOAD, 8'h12, 8'h12, 8'h00);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
